// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants for the register file and busy scoreboard
package regfile_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_ADDR_W = 5;
    // Entry that reads as zero and ignores writes/issues when ZERO_REG=1.
    localparam int ZERO_ADDR  = 0;

endpackage

// File: rtl/regfile_busy_table.sv
// rtl/regfile_busy_table.sv - per-register pending-write scoreboard with two lookups
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   set_en, set_addr         issue: mark set_addr busy at the edge
//   clr_en, clr_addr         writeback: clear clr_addr at the edge
//   lookup_addr1/2           combinational lookup addresses
//   busy1/2                  busy state of the looked-up entries
module regfile_busy_table
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] lookup_addr1,
    input  logic [ADDR_W-1:0] lookup_addr2,
    output logic              busy1,
    output logic              busy2
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_ADDR);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             set_ok;
    logic             clr_ok;

    assign set_ok = set_en && !((ZERO_REG != 0) && (set_addr == ZADDR));
    assign clr_ok = clr_en && !((ZERO_REG != 0) && (clr_addr == ZADDR));

    // Clear first, then set: on a shared address the newer producer stays pending.
    always_comb begin
        busy_d = busy_q;
        if (clr_ok) busy_d[clr_addr] = 1'b0;
        if (set_ok) busy_d[set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    function automatic logic lookup(input logic [DEPTH-1:0]  vec,
                                    input logic [ADDR_W-1:0] a,
                                    input logic              wen,
                                    input logic [ADDR_W-1:0] wa);
        logic r;
        r = vec[a];
        // A write landing this cycle makes the forwarded value available now.
        if ((BYPASS != 0) && wen && (wa == a)) r = 1'b0;
        if ((ZERO_REG != 0) && (a == ZADDR))   r = 1'b0;
        return r;
    endfunction

    always_comb begin
        busy1 = lookup(busy_q, lookup_addr1, clr_en, clr_addr);
        busy2 = lookup(busy_q, lookup_addr2, clr_en, clr_addr);
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 2R/1W register file with zero reg, bypass and busy scoreboard
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   readaddr1/2, readdata1/2       read ports (combinational or registered by READ_REG)
//   busy1/2                        pending-write flag for readaddr1/2 (always combinational)
//   writeaddr, writedata, wrenable write port; a write also clears busy[writeaddr]
//   issue_en, issue_addr           mark a destination busy
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] readaddr1,
    input  logic [ADDR_W-1:0] readaddr2,
    output logic [WIDTH-1:0]  readdata1,
    output logic [WIDTH-1:0]  readdata2,
    output logic              busy1,
    output logic              busy2,
    input  logic [ADDR_W-1:0] writeaddr,
    input  logic [WIDTH-1:0]  writedata,
    input  logic              wrenable,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_ADDR);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic [WIDTH-1:0] rd1_c;
    logic [WIDTH-1:0] rd2_c;

    assign wr_ok = wrenable && !((ZERO_REG != 0) && (writeaddr == ZADDR));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[writeaddr] <= writedata;
        end
    end

    // Zero register has the last word so it wins over a forwarded write to entry 0.
    always_comb begin
        rd1_c = mem[readaddr1];
        rd2_c = mem[readaddr2];
        if ((BYPASS != 0) && wrenable && (writeaddr == readaddr1)) rd1_c = writedata;
        if ((BYPASS != 0) && wrenable && (writeaddr == readaddr2)) rd2_c = writedata;
        if ((ZERO_REG != 0) && (readaddr1 == ZADDR)) rd1_c = '0;
        if ((ZERO_REG != 0) && (readaddr2 == ZADDR)) rd2_c = '0;
    end

    generate
        if (READ_REG != 0) begin : g_rd_reg
            logic [WIDTH-1:0] rd1_q;
            logic [WIDTH-1:0] rd2_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd1_q <= '0;
                    rd2_q <= '0;
                end else begin
                    rd1_q <= rd1_c;
                    rd2_q <= rd2_c;
                end
            end
            assign readdata1 = rd1_q;
            assign readdata2 = rd2_q;
        end else begin : g_rd_comb
            assign readdata1 = rd1_c;
            assign readdata2 = rd2_c;
        end
    endgenerate

    regfile_busy_table #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_busy (
        .clk          (clk),
        .reset        (reset),
        .set_en       (issue_en),
        .set_addr     (issue_addr),
        .clr_en       (wrenable),
        .clr_addr     (writeaddr),
        .lookup_addr1 (readaddr1),
        .lookup_addr2 (readaddr2),
        .busy1        (busy1),
        .busy2        (busy2)
    );

endmodule
